// File: rtl/frac_lut4_cfg_writer_pkg.sv
// Shared definitions for the frac_lut4 configuration writer: state encoding,
// LUT word geometry and the word-counter width helper.
package frac_lut4_cfg_writer_pkg;

  localparam int LUT_WORD_W = 16;
  localparam int BIT_CNT_W  = 5;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT_IDX = BIT_CNT_W'(LUT_WORD_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Wide enough to hold NUM_LUTS itself, so the counter never wraps in a pass.
  function automatic int word_cnt_width(input int n_luts);
    return $clog2(n_luts + 1);
  endfunction

endpackage

// File: rtl/frac_lut4_cfg_shifter.sv
// 16-bit LSB-first configuration shift register with its bit counter.
// o_last flags the 16th shift cycle of the current word.
module frac_lut4_cfg_shifter
  import frac_lut4_cfg_writer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [LUT_WORD_W-1:0] i_data,
  input  logic                  i_shift,
  output logic                  o_bit0,
  output logic                  o_last
);

  logic [LUT_WORD_W-1:0] r_sr;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_sr      <= i_data;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_sr      <= {1'b0, r_sr[LUT_WORD_W-1:1]};
      r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign o_bit0 = r_sr[0];
  assign o_last = (r_bit_cnt == LAST_BIT_IDX);

endmodule

// File: rtl/frac_lut4_cfg_writer.sv
// Streams NUM_LUTS truth-table words LSB-first into a frac_lut4 config chain,
// then pulses cfg_latch once to make the new masks active.
module frac_lut4_cfg_writer
  import frac_lut4_cfg_writer_pkg::*;
#(
  parameter int NUM_LUTS  = 4,
  parameter int SHIFT_LEN = 16
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  word_valid,
  input  logic [LUT_WORD_W-1:0] word_data,
  output logic                  word_ready,
  output logic                  cfg_sdo,
  output logic                  cfg_sen,
  output logic                  cfg_latch,
  output logic                  busy,
  output logic                  done
);

  localparam int WCW = word_cnt_width(NUM_LUTS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_LUTS - 1);

  generate
    if (NUM_LUTS < 1 || NUM_LUTS > 256) begin : g_bad_num_luts
      $error("frac_lut4_cfg_writer: NUM_LUTS must be in 1..256");
    end
    if (SHIFT_LEN != LUT_WORD_W) begin : g_bad_shift_len
      $error("frac_lut4_cfg_writer: SHIFT_LEN must be 16");
    end
  endgenerate

  state_e         r_state;
  logic [WCW-1:0] r_word_cnt;
  logic           r_word_ready;
  logic           r_cfg_sen;
  logic           r_cfg_latch;
  logic           r_busy;
  logic           r_done;

  logic           w_in_load;
  logic           w_in_shift;
  logic           w_abort_pass;
  logic           w_xfer;
  logic           w_shift;
  logic           w_sr_bit0;
  logic           w_last_bit;

  assign w_in_load    = (r_state == ST_LOAD);
  assign w_in_shift   = (r_state == ST_SHIFT);
  assign w_abort_pass = abort && (w_in_load || w_in_shift);
  // Abort wins over a handshake landing in the same cycle.
  assign w_xfer       = w_in_load && word_valid && !abort;
  assign w_shift      = w_in_shift && !abort;

  frac_lut4_cfg_shifter u_shifter (
    .i_clk   (C),
    .i_rst_n (R),
    .i_clear (w_abort_pass),
    .i_load  (w_xfer),
    .i_data  (word_data),
    .i_shift (w_shift),
    .o_bit0  (w_sr_bit0),
    .o_last  (w_last_bit)
  );

  // Outputs are registered alongside the state so each reflects the state it belongs to.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_state      <= ST_IDLE;
      r_word_cnt   <= '0;
      r_word_ready <= 1'b0;
      r_cfg_sen    <= 1'b0;
      r_cfg_latch  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_word_cnt   <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_word_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_state      <= ST_IDLE;
            r_word_ready <= 1'b0;
            r_busy       <= 1'b0;
          end else if (word_valid) begin
            r_state      <= ST_SHIFT;
            r_word_ready <= 1'b0;
            r_cfg_sen    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            r_cfg_sen <= 1'b0;
            r_busy    <= 1'b0;
          end else if (w_last_bit) begin
            r_cfg_sen <= 1'b0;
            if (r_word_cnt < LAST_WORD) begin
              r_state      <= ST_LOAD;
              r_word_cnt   <= r_word_cnt + WCW'(1);
              r_word_ready <= 1'b1;
            end else begin
              r_state     <= ST_LATCH;
              r_cfg_latch <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          r_state     <= ST_DONE;
          r_cfg_latch <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_word_ready <= 1'b0;
          r_cfg_sen    <= 1'b0;
          r_cfg_latch  <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready = r_word_ready;
  assign cfg_sen    = r_cfg_sen;
  assign cfg_sdo    = r_cfg_sen & w_sr_bit0;
  assign cfg_latch  = r_cfg_latch;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
